// File: rtl/countdown_pkg.sv
// Shared types and segment constants for the countdown display path.
package countdown_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {UNITS = 1'b0, TENS = 1'b1} slot_t;

endpackage

// File: rtl/tone_gen.sv
// Square-wave buzzer driver; once started, a burst lasts at least MIN_HALF half-periods.
module tone_gen #(
  parameter int TONE_DIV = 12500,
  parameter int MIN_HALF = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic beep,
  output logic buzzer
);

  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int HW = $clog2(MIN_HALF + 1);
  localparam logic [TW-1:0] TMAX = TW'(TONE_DIV - 1);
  localparam logic [HW-1:0] HMAX = HW'(MIN_HALF);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} tstate_t;

  tstate_t       state;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      tcnt   <= '0;
      hcnt   <= '0;
      buzzer <= 1'b0;
    end else if (state == IDLE) begin
      if (beep) state <= ACTIVE;
    end else if (!beep && hcnt == HMAX) begin
      // Stopping takes priority over a coincident half-period wrap.
      state  <= IDLE;
      tcnt   <= '0;
      hcnt   <= '0;
      buzzer <= 1'b0;
    end else if (tcnt == TMAX) begin
      tcnt   <= '0;
      buzzer <= ~buzzer;
      if (hcnt != HMAX) hcnt <= hcnt + 1'b1;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_display_driver.sv
// Two-digit multiplexed display driver with frame-coherent capture, anti-ghost
// blanking, optional leading-zero suppression and a buzzer tone generator.
module countdown_display_driver
  import countdown_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int BLANK    = 250,
  parameter int LZ_BLANK = 1,
  parameter int TONE_DIV = 12500,
  parameter int MIN_HALF = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEG_W-1:0] bs1,
  input  logic [SEG_W-1:0] bs0,
  input  logic             beep,
  output logic [SEG_W-1:0] seg,
  output logic [1:0]       dig_en,
  output logic             buzzer
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CMAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CBLANK = CW'(BLANK);

  slot_t            slot;
  slot_t            slot_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             wrap;
  logic             tens_lz;
  logic [1:0]       dig_en_nxt;
  logic [SEG_W-1:0] sh1;
  logic [SEG_W-1:0] sh0;

  always_comb begin
    wrap       = (cnt == CMAX);
    cnt_nxt    = wrap ? '0 : cnt + 1'b1;
    slot_nxt   = slot;
    if (wrap) slot_nxt = (slot == UNITS) ? TENS : UNITS;
    tens_lz    = (LZ_BLANK != 0) && (sh1 == SEG_ZERO);
    dig_en_nxt = 2'b00;
    // Enables are computed for the upcoming cycle so they drop on the same edge seg changes.
    if (cnt_nxt >= CBLANK) begin
      if (slot_nxt == UNITS)  dig_en_nxt = 2'b01;
      else if (!tens_lz)      dig_en_nxt = 2'b10;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      slot   <= UNITS;
      sh1    <= SEG_BLANK;
      sh0    <= SEG_BLANK;
      seg    <= SEG_BLANK;
      dig_en <= 2'b00;
    end else begin
      cnt    <= cnt_nxt;
      slot   <= slot_nxt;
      dig_en <= dig_en_nxt;
      if (wrap) begin
        if (slot == TENS) begin
          // Both digits captured together so a frame never mixes two input values.
          sh1 <= bs1;
          sh0 <= bs0;
          seg <= bs0;
        end else begin
          seg <= sh1;
        end
      end
    end
  end

  tone_gen #(
    .TONE_DIV(TONE_DIV),
    .MIN_HALF(MIN_HALF)
  ) u_tone (
    .clock (clock),
    .reset (reset),
    .beep  (beep),
    .buzzer(buzzer)
  );

endmodule

// File: tb/tb_countdown_display_driver.sv
// Directed bench for countdown_display_driver: scan table, tone bursts, async reset.
module tb_countdown_display_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] bs1 = 7'h00;
  logic [6:0] bs0 = 7'h00;
  logic       beep = 1'b0;
  logic [6:0] seg, seg_n;
  logic [1:0] dig_en, dig_en_n;
  logic       buzzer, buzzer_n;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  countdown_display_driver #(
    .SCAN_DIV(8), .BLANK(2), .LZ_BLANK(1), .TONE_DIV(4), .MIN_HALF(4)
  ) dut (
    .clock(clock), .reset(reset), .bs1(bs1), .bs0(bs0), .beep(beep),
    .seg(seg), .dig_en(dig_en), .buzzer(buzzer)
  );

  countdown_display_driver #(
    .SCAN_DIV(8), .BLANK(2), .LZ_BLANK(0), .TONE_DIV(4), .MIN_HALF(4)
  ) dut_nlz (
    .clock(clock), .reset(reset), .bs1(bs1), .bs0(bs0), .beep(beep),
    .seg(seg_n), .dig_en(dig_en_n), .buzzer(buzzer_n)
  );

  typedef struct packed {
    int         cyc;
    logic [6:0] b1;
    logic [6:0] b0;
    logic [6:0] seg;
    logic [1:0] en;
    logic [1:0] en_n;
  } vec_t;

  vec_t vt[31];
  int   nv = 0;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input int c, input logic [6:0] b1, input logic [6:0] b0,
                     input logic [6:0] s, input logic [1:0] e, input logic [1:0] en);
    vt[nv].cyc  = c;
    vt[nv].b1   = b1;
    vt[nv].b0   = b0;
    vt[nv].seg  = s;
    vt[nv].en   = e;
    vt[nv].en_n = en;
    nv++;
  endtask

  // Checks each row at its cycle, then drives that row's inputs.
  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      while (cyc < vt[i].cyc) tick();
      check("seg", {25'd0, seg}, {25'd0, vt[i].seg});
      check("dig_en", {30'd0, dig_en}, {30'd0, vt[i].en});
      check("dig_en_nolz", {30'd0, dig_en_n}, {30'd0, vt[i].en_n});
      bs1 = vt[i].b1;
      bs0 = vt[i].b0;
    end
  endtask

  // Bit m of pat is beep sampled at edge E+m; bit m of exp is buzzer after that edge.
  task automatic run_tone(input string name, input logic [63:0] pat, input logic [63:0] exp,
                          input int len);
    for (int m = 0; m < len; m++) begin
      beep = pat[m];
      tick();
      check(name, {31'd0, buzzer}, {31'd0, exp[m]});
    end
    beep = 1'b0;
  endtask

  initial begin
    // Frame 1 blank, then 12 shown; mid-UNITS change of both inputs; tens zero suppression.
    add( 0, 7'h06, 7'h5B, 7'h00, 2'b00, 2'b00);
    add( 1, 7'h06, 7'h5B, 7'h00, 2'b00, 2'b00);
    add( 2, 7'h06, 7'h5B, 7'h00, 2'b01, 2'b01);
    add( 7, 7'h06, 7'h5B, 7'h00, 2'b01, 2'b01);
    add( 8, 7'h06, 7'h5B, 7'h00, 2'b00, 2'b00);
    add(10, 7'h06, 7'h5B, 7'h00, 2'b10, 2'b10);
    add(15, 7'h06, 7'h5B, 7'h00, 2'b10, 2'b10);
    add(16, 7'h06, 7'h5B, 7'h5B, 2'b00, 2'b00);
    add(17, 7'h06, 7'h5B, 7'h5B, 2'b00, 2'b00);
    add(18, 7'h06, 7'h5B, 7'h5B, 2'b01, 2'b01);
    add(23, 7'h06, 7'h5B, 7'h5B, 2'b01, 2'b01);
    add(24, 7'h06, 7'h5B, 7'h06, 2'b00, 2'b00);
    add(26, 7'h06, 7'h5B, 7'h06, 2'b10, 2'b10);
    add(31, 7'h06, 7'h5B, 7'h06, 2'b10, 2'b10);
    add(32, 7'h06, 7'h5B, 7'h5B, 2'b00, 2'b00);
    add(36, 7'h66, 7'h4F, 7'h5B, 2'b01, 2'b01);
    add(37, 7'h66, 7'h4F, 7'h5B, 2'b01, 2'b01);
    add(40, 7'h66, 7'h4F, 7'h06, 2'b00, 2'b00);
    add(42, 7'h66, 7'h4F, 7'h06, 2'b10, 2'b10);
    add(48, 7'h66, 7'h4F, 7'h4F, 2'b00, 2'b00);
    add(50, 7'h66, 7'h4F, 7'h4F, 2'b01, 2'b01);
    add(56, 7'h3F, 7'h4F, 7'h66, 2'b00, 2'b00);
    add(58, 7'h3F, 7'h4F, 7'h66, 2'b10, 2'b10);
    add(64, 7'h3F, 7'h4F, 7'h4F, 2'b00, 2'b00);
    add(66, 7'h3F, 7'h4F, 7'h4F, 2'b01, 2'b01);
    add(72, 7'h3F, 7'h4F, 7'h3F, 2'b00, 2'b00);
    add(74, 7'h3F, 7'h4F, 7'h3F, 2'b00, 2'b10);
    add(79, 7'h3F, 7'h4F, 7'h3F, 2'b00, 2'b10);
    add(80, 7'h3F, 7'h4F, 7'h4F, 2'b00, 2'b00);
    add(82, 7'h3F, 7'h4F, 7'h4F, 2'b01, 2'b01);

    #2 reset = 1'b0;
    bs1 = 7'h06;
    bs0 = 7'h5B;
    repeat (2) tick();
    check("rst_seg", {25'd0, seg}, 32'd0);
    check("rst_dig_en", {30'd0, dig_en}, 32'd0);
    check("rst_buzzer", {31'd0, buzzer}, 32'd0);
    reset = 1'b1;
    cyc   = 0;
    run_table(0, nv - 1);

    run_tone("tone_hold",   64'h0000_00FF_FFFF_FFFF, 64'h0000_00F0_F0F0_F0F0, 44);
    run_tone("tone_pulse",  64'h0000_0000_0000_0001, 64'h0000_0000_0000_F0F0, 26);
    run_tone("tone_rerise", 64'h0000_0000_001F_C001, 64'h0000_0000_0010_F0F0, 28);

    // Reset mid-burst and mid-UNITS slot.
    while (cyc % 16 != 0) tick();
    beep = 1'b1;
    repeat (5) tick();
    check("pre_rst_dig_en", {30'd0, dig_en}, 32'd1);
    check("pre_rst_buzzer", {31'd0, buzzer}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_seg", {25'd0, seg}, 32'd0);
    check("async_rst_dig_en", {30'd0, dig_en}, 32'd0);
    check("async_rst_buzzer", {31'd0, buzzer}, 32'd0);
    beep = 1'b0;
    bs1  = 7'h06;
    bs0  = 7'h5B;
    repeat (2) tick();
    reset = 1'b1;
    cyc   = 0;
    run_table(0, 14);
    check("post_rst_buzzer", {31'd0, buzzer}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
